// File: rtl/mux_stream_n.sv
// N-input valid/ready stream mux with a registered output stage.
// Grant by external select (mode=0) or round-robin from a rotating pointer (mode=1).
module mux_stream_n #(
    parameter int WIDTH = 32,
    parameter int CHANNELS = 16,
    localparam int SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready
);

    logic             accept;
    logic             xfer;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] ptr;
    logic             hi_vld;
    logic             lo_vld;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    assign accept = !out_valid || out_ready;

    // Round-robin: lowest valid index at or above ptr, else wrap to lowest valid overall.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                lo_vld = 1'b1;
                lo_idx = SEL_W'(k);
                if (SEL_W'(k) >= ptr) begin
                    hi_vld = 1'b1;
                    hi_idx = SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (!mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (select == SEL_W'(k) && in_valid[k]) begin
                    gnt_vld = 1'b1;
                    gnt     = SEL_W'(k);
                end
            end
        end else begin
            gnt_vld = lo_vld;
            gnt     = hi_vld ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (gnt == SEL_W'(k)) begin
                gnt_data    = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = reset && accept && gnt_vld;
            end
        end
    end

    assign xfer = reset && accept && gnt_vld;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_chan  <= gnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && mode) begin
                ptr <= (int'(gnt) == CHANNELS - 1) ? '0 : gnt + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_n.sv
// Scoreboard bench for mux_stream_n: a 16-channel/32-bit and a 12-channel/8-bit instance.
// Driver pushes expected transfers; negedge monitors pop on output handshakes.
module tb_mux_stream_n;

    localparam int W   = 32;
    localparam int N   = 16;
    localparam int SW  = 4;
    localparam int W2  = 8;
    localparam int N2  = 12;
    localparam int SW2 = 4;

    typedef struct {
        int          chan;
        logic [31:0] data;
    } exp_t;

    logic            clock = 1'b0;
    logic            reset;

    logic            mode;
    logic [SW-1:0]   select;
    logic [N-1:0]    in_valid;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_ready;

    logic            mode2;
    logic [SW2-1:0]  select2;
    logic [N2-1:0]   in_valid2;
    logic [N2*W2-1:0] in_data2;
    logic [N2-1:0]   in_ready2;
    logic            out_valid2;
    logic [W2-1:0]   out_data2;
    logic [SW2-1:0]  out_chan2;
    logic            out_ready2;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1;
    exp_t e2;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mux_stream_n #(.WIDTH(W), .CHANNELS(N)) dut (
        .clock(clock), .reset(reset), .mode(mode), .select(select),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready)
    );

    mux_stream_n #(.WIDTH(W2), .CHANNELS(N2)) dut12 (
        .clock(clock), .reset(reset), .mode(mode2), .select(select2),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_data(out_data2), .out_chan(out_chan2),
        .out_ready(out_ready2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon16_extra: got chan %0d data %h, required no output", out_chan, out_data);
            end else begin
                e1 = q1.pop_front();
                chk("mon16_chan", 64'(out_chan), 64'(e1.chan));
                chk("mon16_data", 64'(out_data), 64'(e1.data));
            end
        end
    end

    always @(negedge clock) begin
        if (reset && out_valid2 && out_ready2) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon12_extra: got chan %0d data %h, required no output", out_chan2, out_data2);
            end else begin
                e2 = q2.pop_front();
                chk("mon12_chan", 64'(out_chan2), 64'(e2.chan));
                chk("mon12_data", 64'(out_data2), 64'(e2.data[7:0]));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rr16(input logic [N-1:0] v, input int g);
        logic [N-1:0] one;
        one = 1;
        in_valid = v;
        #1;
        chk("rr16_ready", 64'(in_ready), 64'(one << g));
        q1.push_back('{g, 32'(g)});
        step();
    endtask

    initial begin
        logic [N2-1:0] one2;
        one2 = 1;
        reset = 1'b0;
        mode = 1'b1;
        select = '0;
        in_valid = '1;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'(k);
        mode2 = 1'b0;
        select2 = '0;
        in_valid2 = '0;
        out_ready2 = 1'b1;
        for (int k = 0; k < N2; k++) in_data2[k*W2 +: W2] = 8'(8'hA0 + k);

        step();
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_chan", 64'(out_chan), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);

        reset = 1'b1;
        in_valid = '0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        mode = 1'b0;
        select = 4'd5;
        in_data[5*W +: W] = 32'hDEAD_BEEF;
        in_valid = '1;
        out_ready = 1'b0;
        #1;
        chk("dir_in_ready", 64'(in_ready), 64'h0020);
        q1.push_back('{5, 32'hDEAD_BEEF});
        step();
        chk("dir_out_valid", 64'(out_valid), 64'd1);
        chk("dir_out_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("dir_out_chan", 64'(out_chan), 64'd5);
        chk("dir_bp_ready", 64'(in_ready), 64'd0);
        repeat (3) begin
            step();
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'hDEAD_BEEF);
            chk("hold_chan", 64'(out_chan), 64'd5);
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = '0;
        out_ready = 1'b1;
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_data_hold", 64'(out_data), 64'hDEAD_BEEF);

        in_data[5*W +: W] = 32'd5;
        mode = 1'b1;
        for (int i = 0; i < 18; i++) rr16('1, i % N);
        rr16(16'h8001, 15);
        rr16(16'h8001, 0);
        rr16(16'h8001, 15);
        rr16(16'h0410, 4);
        rr16(16'h0410, 10);
        rr16(16'h0410, 4);
        rr16(16'h0410, 10);
        in_valid = '0;
        step();
        chk("sparse_fall", 64'(out_valid), 64'd0);

        out_ready = 1'b0;
        rr16(16'h0040, 6);
        in_valid = '0;
        chk("mid_out_valid", 64'(out_valid), 64'd1);
        chk("mid_out_chan", 64'(out_chan), 64'd6);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        in_valid = '1;
        #1;
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        q1.delete();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        rr16('1, 0);
        in_valid = '0;
        step();

        mode2 = 1'b0;
        select2 = 4'd13;
        in_valid2 = '1;
        #1;
        chk("np2_oor_ready", 64'(in_ready2), 64'd0);
        step();
        chk("np2_oor_valid", 64'(out_valid2), 64'd0);
        select2 = 4'd11;
        #1;
        chk("np2_sel11_ready", 64'(in_ready2), 64'h800);
        q2.push_back('{11, 32'hAB});
        step();
        mode2 = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            chk("np2_rr_ready", 64'(in_ready2), 64'(one2 << (i % N2)));
            q2.push_back('{i % N2, 32'(8'hA0 + (i % N2))});
            step();
        end
        in_valid2 = '0;
        step();
        chk("np2_fall", 64'(out_valid2), 64'd0);
        step();

        chk("q16_empty", 64'(q1.size()), 64'd0);
        chk("q12_empty", 64'(q2.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
